fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 21 ++
 rtl/fetch_unit.sv | 37 +++
 tb/tb_fetch_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: decode/imem handshake bundle between the fetch unit and its neighbours
interface fetch_unit_if;
  logic        stall;
  logic        tgt_valid;
  logic [31:0] tgt_addr;
  logic        annul;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        misalign;
  modport master (
    output stall, tgt_valid, tgt_addr, annul, imem_data,
    input  imem_addr, instr, instr_pc, instr_valid, misalign
  );
  modport slave (
    input  stall, tgt_valid, tgt_addr, annul, imem_data,
    output imem_addr, instr, instr_pc, instr_valid, misalign
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: SPARC PC/nPC fetch stage with delayed transfers, annul and IF/ID register
module fetch_unit (
  input logic        clk,
  input logic        clr,
  fetch_unit_if.slave bus
);
  localparam logic [31:0] NOP = 32'h0100_0000;
  logic [31:0] r_pc, r_npc, r_instr, r_instr_pc;
  logic        r_instr_valid, r_misalign;
  logic [31:0] w_npc_next;
  logic        w_bad_tgt;
  assign w_npc_next = bus.tgt_valid ? {bus.tgt_addr[31:2], 2'b00} : r_npc + 32'd4;
  assign w_bad_tgt  = bus.tgt_valid & |bus.tgt_addr[1:0];
  // advance PC/nPC and capture the fetched word; stall freezes everything, clr overrides all
  always_ff @(posedge clk) begin
    if (clr) begin
      r_pc          <= '0;
      r_npc         <= 32'd4;
      r_instr       <= NOP;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_misalign    <= 1'b0;
    end else if (!bus.stall) begin
      r_pc          <= r_npc;
      r_npc         <= w_npc_next;
      r_instr       <= bus.annul ? NOP : bus.imem_data;
      r_instr_pc    <= r_pc;
      r_instr_valid <= !bus.annul;
      r_misalign    <= r_misalign | w_bad_tgt;
    end
  end
  assign bus.imem_addr   = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_instr_valid;
  assign bus.misalign    = r_misalign;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed spec scenarios plus random traffic against a fetch-stream model
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0100_0000;
  logic clk = 1'b0;
  logic clr = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  logic [31:0] m_pc, m_npc, m_instr, m_ipc;
  logic        m_iv, m_mis;
  fetch_unit_if bus ();
  fetch_unit dut (.clk(clk), .clr(clr), .bus(bus));
  assign bus.imem_data = 32'hA000_0000 | bus.imem_addr;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic c, input logic s, input logic tv, input logic [31:0] ta, input logic an);
    @(negedge clk);
    clr = c; bus.stall = s; bus.tgt_valid = tv; bus.tgt_addr = ta; bus.annul = an;
    @(posedge clk);
    if (c) begin
      m_pc = 0; m_npc = 4; m_instr = NOP; m_ipc = 0; m_iv = 0; m_mis = 0;
    end else if (!s) begin
      m_instr = an ? NOP : (32'hA000_0000 | m_pc);
      m_ipc   = m_pc;
      m_iv    = !an;
      m_mis   = m_mis | (tv && ta[1:0] != 2'b00);
      m_pc    = m_npc;
      m_npc   = tv ? (ta & ~32'd3) : m_npc + 32'd4;
    end
    #1;
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("instr", bus.instr, m_instr);
    chk("instr_pc", bus.instr_pc, m_ipc);
    chk("instr_valid", {31'd0, bus.instr_valid}, {31'd0, m_iv});
    chk("misalign", {31'd0, bus.misalign}, {31'd0, m_mis});
  endtask
  initial begin
    logic [31:0] held_pc, held_instr;
    bus.stall = 0; bus.tgt_valid = 0; bus.tgt_addr = 0; bus.annul = 0;
    cyc(1, 0, 0, 0, 0);
    chk("rst_imem", bus.imem_addr, 32'h0);
    chk("rst_instr", bus.instr, NOP);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    chk("free_ipc8", bus.instr_pc, 32'h8);
    chk("free_imem12", bus.imem_addr, 32'hC);
    chk("free_valid", {31'd0, bus.instr_valid}, 32'd1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h40, 0);
    cyc(0, 0, 0, 0, 0);
    chk("br_slot", bus.instr_pc, 32'hC);
    cyc(0, 0, 0, 0, 0);
    chk("br_tgt", bus.instr_pc, 32'h40);
    cyc(0, 0, 0, 0, 0);
    chk("br_tgt4", bus.instr_pc, 32'h44);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h40, 0);
    cyc(0, 0, 0, 0, 1);
    chk("an_instr", bus.instr, NOP);
    chk("an_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("an_ipc", bus.instr_pc, 32'hC);
    cyc(0, 0, 0, 0, 0);
    chk("an_tgt", bus.instr_pc, 32'h40);
    chk("an_tgt_valid", {31'd0, bus.instr_valid}, 32'd1);
    held_pc = bus.imem_addr; held_instr = bus.instr;
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 32'h200, 1);
    cyc(0, 1, 0, 0, 0);
    chk("stall_pc", bus.imem_addr, held_pc);
    chk("stall_instr", bus.instr, held_instr);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("stall_resume", bus.imem_addr, held_pc + 32'd8);
    cyc(0, 0, 1, 32'hFFFF_FFFC, 0);
    cyc(0, 0, 0, 0, 0);
    chk("wrap_a", bus.imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0);
    chk("wrap_b", bus.imem_addr, 32'h0);
    cyc(0, 0, 1, 32'h41, 0);
    chk("wrap_c", bus.imem_addr, 32'h4);
    chk("mis_set", {31'd0, bus.misalign}, 32'd1);
    cyc(0, 0, 0, 0, 0);
    chk("mis_npc", bus.imem_addr, 32'h40);
    cyc(0, 0, 0, 0, 0);
    chk("mis_sticky", {31'd0, bus.misalign}, 32'd1);
    cyc(1, 1, 1, 32'h300, 1);
    chk("clr_pc", bus.imem_addr, 32'h0);
    chk("clr_mis", {31'd0, bus.misalign}, 32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("clr_npc", bus.imem_addr, 32'h4);
    for (int i = 0; i < 500; i++) begin
      logic [31:0] ta;
      ta = $urandom;
      if ($urandom_range(0, 7) != 0) ta[1:0] = 2'b00;
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 4) == 0, ta, $urandom_range(0, 5) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
